// File: rtl/hc595_chain_driver.sv
// Serial driver for a chain of 74HC595 shift registers: one-deep frame buffer,
// configurable SCLK rate and bit order, rclk latch pulse and PWM dimming on oe_n.
module hc595_chain_driver #(
  parameter int DATA_W    = 16,
  parameter int SCLK_DIV  = 2,
  parameter int MSB_FIRST = 1,
  parameter int BRIGHT_W  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [BRIGHT_W-1:0] brightness,
  output logic                busy,
  output logic                done,
  output logic                sclk,
  output logic                rclk,
  output logic                dio,
  output logic                oe_n,
  output logic [1:0]          dbg_state
);

  localparam int DIV_W = (2 * SCLK_DIV > 2) ? $clog2(2 * SCLK_DIV) : 1;
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(SCLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(2 * SCLK_DIV - 1);
  localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BITS       = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t              r_state;
  logic [DIV_W-1:0]    r_div;
  logic [CNT_W-1:0]    r_bits;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   r_pend;
  logic                r_pend_vld;
  logic [BRIGHT_W-1:0] r_pwm;
  logic                r_sclk, r_rclk, r_dio, r_busy, r_done_pre, r_done, r_oe_n;

  state_t              w_state_nxt;
  logic [DIV_W-1:0]    w_div_nxt;
  logic [CNT_W-1:0]    w_bits_nxt;
  logic [DATA_W-1:0]   w_shreg_nxt;
  logic                w_load, w_latch_end;
  logic                w_sclk, w_rclk, w_dio, w_busy;

  // Handshake: a frame transfers on any edge where in_valid & in_ready; in_ready
  // is the registered inverse of the buffer-full flag and does not depend on in_valid.
  assign in_ready = ~r_pend_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_vld <= 1'b0;
      r_pend     <= '0;
    end else if (w_load) begin
      r_pend_vld <= 1'b0;
    end else if (in_valid && !r_pend_vld) begin
      r_pend     <= in_data;
      r_pend_vld <= 1'b1;
    end
  end

  // State register and shift datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bits  <= '0;
      r_shreg <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bits  <= w_bits_nxt;
      r_shreg <= w_shreg_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bits_nxt  = r_bits;
    w_shreg_nxt = r_shreg;
    w_load      = 1'b0;
    w_latch_end = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend_vld) begin
          w_load      = 1'b1;
          w_shreg_nxt = r_pend;
          w_bits_nxt  = BITS;
          w_div_nxt   = '0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (r_div == DIV_LAST) begin
          w_div_nxt   = '0;
          w_shreg_nxt = (MSB_FIRST != 0) ? (r_shreg << 1) : (r_shreg >> 1);
          w_bits_nxt  = r_bits - 1'b1;
          if (r_bits == LAST_BIT) w_state_nxt = S_LATCH;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      S_LATCH: begin
        if (r_div == LATCH_LAST) begin
          w_div_nxt   = '0;
          w_latch_end = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Pin values are decoded from the current state and registered, so every pin
  // lags the state by one cycle and is glitch-free at the board.
  always_comb begin
    w_sclk = 1'b0;
    w_rclk = 1'b0;
    w_dio  = r_dio;
    w_busy = 1'b0;
    case (r_state)
      S_SHIFT: begin
        w_busy = 1'b1;
        w_dio  = (MSB_FIRST != 0) ? r_shreg[DATA_W-1] : r_shreg[0];
        w_sclk = (r_div >= DIV_HALF);
      end
      S_LATCH: begin
        w_busy = 1'b1;
        w_rclk = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sclk     <= 1'b0;
      r_rclk     <= 1'b0;
      r_dio      <= 1'b0;
      r_busy     <= 1'b0;
      r_done_pre <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_sclk     <= w_sclk;
      r_rclk     <= w_rclk;
      r_dio      <= w_dio;
      r_busy     <= w_busy;
      r_done_pre <= w_latch_end;
      r_done     <= r_done_pre;
    end
  end

  // PWM dimming runs free of the shift FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pwm  <= '0;
      r_oe_n <= 1'b1;
    end else begin
      r_pwm  <= r_pwm + 1'b1;
      r_oe_n <= ~(r_pwm < brightness);
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sclk      = r_sclk;
  assign rclk      = r_rclk;
  assign dio       = r_dio;
  assign oe_n      = r_oe_n;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: a default 16-bit MSB-first instance and an
// 8-bit LSB-first, SCLK_DIV=1 instance, driven with hand-computed vectors.
module tb_hc595_chain_driver;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int nchecks = 0;
  int nerr    = 0;

  // ---------------- DUT A: defaults ----------------
  logic [15:0] a_in_data;
  logic        a_in_valid, a_in_ready, a_busy, a_done, a_sclk, a_rclk, a_dio, a_oe_n;
  logic [1:0]  a_dbg;
  logic [3:0]  bright;

  hc595_chain_driver #(.DATA_W(16), .SCLK_DIV(2), .MSB_FIRST(1), .BRIGHT_W(4)) u_a (
    .clk(clk), .rst(rst), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .brightness(bright), .busy(a_busy), .done(a_done),
    .sclk(a_sclk), .rclk(a_rclk), .dio(a_dio), .oe_n(a_oe_n), .dbg_state(a_dbg)
  );

  // ---------------- DUT B: 8 bit, LSB first, fast sclk ----------------
  logic [7:0] b_in_data;
  logic       b_in_valid, b_in_ready, b_busy, b_done, b_sclk, b_rclk, b_dio, b_oe_n;
  logic [1:0] b_dbg;

  hc595_chain_driver #(.DATA_W(8), .SCLK_DIV(1), .MSB_FIRST(0), .BRIGHT_W(4)) u_b (
    .clk(clk), .rst(rst), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .brightness(bright), .busy(b_busy), .done(b_done),
    .sclk(b_sclk), .rclk(b_rclk), .dio(b_dio), .oe_n(b_oe_n), .dbg_state(b_dbg)
  );

  // ---------------- check helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    nchecks++;
    nerr++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  // ---------------- scoreboards / pin monitors ----------------
  logic [15:0] exp_q[$];
  logic [7:0]  b_exp_q[$];

  logic [15:0] a_word;
  int a_nbits = 0, a_rclk_rises = 0, a_rclk_w = 0, a_done_cnt = 0, a_done_cyc = 0;
  logic a_sclk_q = 1'b0, a_rclk_q = 1'b0;

  always @(negedge clk) begin
    if (a_sclk === 1'b1 && a_sclk_q === 1'b0) begin
      a_word = {a_word[14:0], a_dio};
      a_nbits++;
    end
    if (a_rclk === 1'b1 && a_rclk_q === 1'b0) begin
      a_rclk_rises++;
      a_rclk_w = 0;
      if (exp_q.size() == 0) fail("a_rclk_unexpected");
      else chk("a_frame", {16'h0, a_word}, {16'h0, exp_q.pop_front()});
    end
    if (a_rclk === 1'b1) a_rclk_w++;
    if (a_done === 1'b1) begin
      a_done_cnt++;
      a_done_cyc = cyc;
    end
    a_sclk_q = a_sclk;
    a_rclk_q = a_rclk;
  end

  logic [7:0] b_word;
  int b_nbits = 0, b_done_cnt = 0, b_done_cyc = 0, b_rise_prev = 0, b_rise_last = 0;
  logic b_sclk_q = 1'b0, b_rclk_q = 1'b0;

  always @(negedge clk) begin
    if (b_sclk === 1'b1 && b_sclk_q === 1'b0) begin
      b_word = {b_word[6:0], b_dio};
      b_nbits++;
      b_rise_prev = b_rise_last;
      b_rise_last = cyc;
    end
    if (b_rclk === 1'b1 && b_rclk_q === 1'b0) begin
      if (b_exp_q.size() == 0) fail("b_rclk_unexpected");
      else chk("b_frame", {24'h0, b_word}, {24'h0, b_exp_q.pop_front()});
    end
    if (b_done === 1'b1) begin
      b_done_cnt++;
      b_done_cyc = cyc;
    end
    b_sclk_q = b_sclk;
    b_rclk_q = b_rclk;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_a_ready();
    int g = 0;
    @(negedge clk);
    while (a_in_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) fail("a_ready_timeout");
  endtask

  task automatic send_a(input logic [15:0] d, input logic [15:0] seq, output int acc);
    wait_a_ready();
    a_in_data  = d;
    a_in_valid = 1'b1;
    exp_q.push_back(seq);
    @(posedge clk);
    #1;
    acc        = cyc;
    a_in_valid = 1'b0;
  endtask

  task automatic wait_done_a(input int target);
    int g = 0;
    while (a_done_cnt < target && g < 1000) begin
      @(negedge clk);
      g++;
    end
    if (a_done_cnt < target) fail("a_done_timeout");
  endtask

  task automatic run_a(input logic [15:0] d, input logic [15:0] seq);
    int acc, d0, r0, n0;
    d0 = a_done_cnt;
    r0 = a_rclk_rises;
    n0 = a_nbits;
    send_a(d, seq, acc);
    wait_done_a(d0 + 1);
    chk("a_done_latency", a_done_cyc - acc, 68);
    chk("a_bit_count", a_nbits - n0, 16);
    chk("a_rclk_pulses", a_rclk_rises - r0, 1);
    chk("a_rclk_width", a_rclk_w, 2);
    repeat (3) @(negedge clk);
    chk("a_done_once", a_done_cnt - d0, 1);
  endtask

  task automatic run_b(input logic [7:0] d, input logic [7:0] seq);
    int acc, d0, n0, g;
    d0 = b_done_cnt;
    n0 = b_nbits;
    g  = 0;
    @(negedge clk);
    while (b_in_ready !== 1'b1 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (g >= 500) fail("b_ready_timeout");
    b_in_data  = d;
    b_in_valid = 1'b1;
    b_exp_q.push_back(seq);
    @(posedge clk);
    #1;
    acc        = cyc;
    b_in_valid = 1'b0;
    g = 0;
    while (b_done_cnt <= d0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (b_done_cnt <= d0) fail("b_done_timeout");
    chk("b_done_latency", b_done_cyc - acc, 19);
    chk("b_bit_count", b_nbits - n0, 8);
    chk("b_sclk_period", b_rise_last - b_rise_prev, 2);
  endtask

  // ---------------- vector tables ----------------
  typedef struct {
    logic [15:0] data;
    logic [15:0] seq;   // dio bits in shift order, first bit at the left
  } vec_a_t;

  typedef struct {
    logic [7:0] data;
    logic [7:0] seq;
  } vec_b_t;

  typedef struct {
    logic [3:0] level;
    int         low_cycles;
  } vec_pwm_t;

  vec_a_t   va[4];
  vec_b_t   vb[3];
  vec_pwm_t vp[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, d0, r0, n0, cnt;

    va[0] = '{data: 16'hABCD, seq: 16'b1010_1011_1100_1101};
    va[1] = '{data: 16'h8001, seq: 16'b1000_0000_0000_0001};
    va[2] = '{data: 16'hFFFF, seq: 16'b1111_1111_1111_1111};
    va[3] = '{data: 16'h0000, seq: 16'b0000_0000_0000_0000};
    vb[0] = '{data: 8'h01, seq: 8'b1000_0000};
    vb[1] = '{data: 8'h0F, seq: 8'b1111_0000};
    vb[2] = '{data: 8'hC6, seq: 8'b0110_0011};
    vp[0] = '{level: 4'd0,  low_cycles: 0};
    vp[1] = '{level: 4'd4,  low_cycles: 16};
    vp[2] = '{level: 4'd15, low_cycles: 60};

    rst        = 1'b1;
    a_in_data  = '0;
    a_in_valid = 1'b0;
    b_in_data  = '0;
    b_in_valid = 1'b0;
    bright     = 4'd0;
    repeat (3) @(negedge clk);

    // reset values
    chk("rst_in_ready", a_in_ready, 1);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_sclk", a_sclk, 0);
    chk("rst_rclk", a_rclk, 0);
    chk("rst_dio", a_dio, 0);
    chk("rst_oe_n", a_oe_n, 1);
    chk("rst_state", a_dbg, 0);
    chk("rst_b_in_ready", b_in_ready, 1);
    rst = 1'b0;

    // single frames, default instance
    for (int i = 0; i < 4; i++) run_a(va[i].data, va[i].seq);

    // single frames, LSB-first instance
    for (int i = 0; i < 3; i++) run_b(vb[i].data, vb[i].seq);

    // back-to-back: second frame accepted while the first shifts
    d0 = a_done_cnt;
    r0 = a_rclk_rises;
    wait_a_ready();
    a_in_data  = 16'h1234;
    a_in_valid = 1'b1;
    exp_q.push_back(16'h1234);
    @(posedge clk);
    #1;
    a_in_data = 16'h5678;
    exp_q.push_back(16'h5678);
    @(negedge clk);
    chk("b2b_ready_low", a_in_ready, 0);
    g = 0;
    while (a_in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_busy_at_second", a_busy, 1);
    chk("b2b_ready_pending", a_in_ready, 0);
    wait_done_a(d0 + 2);
    repeat (3) @(negedge clk);
    chk("b2b_rclk_pulses", a_rclk_rises - r0, 2);
    chk("b2b_done_pulses", a_done_cnt - d0, 2);
    chk("b2b_queue_empty", exp_q.size(), 0);

    // PWM duty over 64-cycle windows
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bright = vp[i].level;
      repeat (4) @(negedge clk);
      cnt = 0;
      repeat (64) begin
        @(negedge clk);
        if (a_oe_n === 1'b0) cnt++;
      end
      chk("pwm_low_cycles", cnt, vp[i].low_cycles);
    end

    // reset mid-shift with a frame pending
    bright = 4'd8;
    d0 = a_done_cnt;
    r0 = a_rclk_rises;
    n0 = a_nbits;
    wait_a_ready();
    a_in_data  = 16'hFFFF;
    a_in_valid = 1'b1;
    exp_q.push_back(16'hFFFF);
    @(posedge clk);
    #1;
    a_in_data = 16'h1357;
    exp_q.push_back(16'h1357);
    g = 0;
    @(negedge clk);
    while (a_in_ready !== 1'b1 && g < 20) begin
      @(negedge clk);
      g++;
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    g = 0;
    while (a_nbits - n0 < 7 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("abort_pending_full", a_in_ready, 0);
    chk("abort_dio_before", a_dio, 1);
    exp_q.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", a_in_ready, 1);
    chk("abort_busy", a_busy, 0);
    chk("abort_sclk", a_sclk, 0);
    chk("abort_rclk", a_rclk, 0);
    chk("abort_dio", a_dio, 0);
    chk("abort_oe_n", a_oe_n, 1);
    chk("abort_state", a_dbg, 0);
    rst = 1'b0;
    repeat (120) @(negedge clk);
    chk("abort_no_rclk", a_rclk_rises - r0, 0);
    chk("abort_no_done", a_done_cnt - d0, 0);
    run_a(16'hC3A5, 16'b1100_0011_1010_0101);

    // reset while rclk is high
    d0 = a_done_cnt;
    r0 = a_rclk_rises;
    wait_a_ready();
    a_in_data  = 16'h5A5A;
    a_in_valid = 1'b1;
    exp_q.push_back(16'b0101_1010_0101_1010);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    g = 0;
    while (a_rclk !== 1'b1 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("latch_rclk_seen", a_rclk, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("latch_rst_rclk", a_rclk, 0);
    chk("latch_rst_done", a_done, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("latch_no_done", a_done_cnt - d0, 0);
    chk("latch_one_rclk", a_rclk_rises - r0, 1);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
